// File: rtl/xmul_arb_if.sv
// Requester/response bundle for xmul_arb.
// Defining XMUL_ARB_LOCK_EN adds the per-requester req_lock vector.
interface xmul_arb_if #(
  parameter int DATA_W = 32,
  parameter int N_REQ  = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic [N_REQ*2-1:0]      req_fns;
`ifdef XMUL_ARB_LOCK_EN
  logic [N_REQ-1:0]        req_lock;
`endif
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_ready;

  modport master (
    output req_valid, req_a, req_b, req_fns, rsp_ready,
`ifdef XMUL_ARB_LOCK_EN
    output req_lock,
`endif
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_fns, rsp_ready,
`ifdef XMUL_ARB_LOCK_EN
    input  req_lock,
`endif
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/xmul_arb.sv
// Round-robin arbiter feeding a two-stage signed multiplier with result-slice select.
// Optional XMUL_ARB_LOCK_EN lets a locked requester keep top priority.
module xmul_arb #(
  parameter int DATA_W = 32,
  parameter int N_REQ  = 4
) (
  input  logic      clk,
  input  logic      rst,
  xmul_arb_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);

  logic [DATA_W-1:0]   a_arr_s   [N_REQ];
  logic [DATA_W-1:0]   b_arr_s   [N_REQ];
  logic [1:0]          fns_arr_s [N_REQ];
  logic                stall_s, grant_s, xfer_s, lock_s;
  logic [ID_W-1:0]     grant_id_s, ptr_inc_s;
  logic [N_REQ-1:0]    ready_s;
  logic [ID_W-1:0]     ptr_q, ptr_d;

  logic                s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [1:0]          s1_fns_q, s1_fns_d;
  logic [ID_W-1:0]     s1_id_q, s1_id_d;

  logic                s2_valid_q, s2_valid_d;
  logic [2*DATA_W-1:0] s2_prod_q, s2_prod_d;
  logic [1:0]          s2_fns_q, s2_fns_d;
  logic [ID_W-1:0]     s2_id_q, s2_id_d;

  logic signed [2*DATA_W-1:0] a_ext_s, b_ext_s, prod_s;
  logic [DATA_W-1:0]          rsp_data_s;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      a_arr_s[i]   = bus.req_a[i*DATA_W +: DATA_W];
      b_arr_s[i]   = bus.req_b[i*DATA_W +: DATA_W];
      fns_arr_s[i] = bus.req_fns[i*2 +: 2];
    end
  end

  // Stage 2 drives the outputs, so a held result is exactly a stall.
  assign stall_s = s2_valid_q && !bus.rsp_ready;

  // Search from ptr_q upward, wrapping, for the first valid requester.
  always_comb begin
    logic [ID_W:0]   sum_v;
    logic [ID_W-1:0] idx_v;
    logic            hit_v;
    grant_s    = 1'b0;
    grant_id_s = '0;
    sum_v      = '0;
    idx_v      = '0;
    hit_v      = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      sum_v      = {1'b0, ptr_q} + (ID_W+1)'(k);
      idx_v      = (sum_v >= (ID_W+1)'(N_REQ)) ? ID_W'(sum_v - (ID_W+1)'(N_REQ))
                                               : sum_v[ID_W-1:0];
      hit_v      = !grant_s && bus.req_valid[idx_v];
      grant_id_s = hit_v ? idx_v : grant_id_s;
      grant_s    = grant_s || hit_v;
    end
  end

  always_comb begin
    ready_s = '0;
    if (!rst && !stall_s && grant_s) begin
      ready_s[grant_id_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign xfer_s    = |ready_s;
  assign ptr_inc_s = (grant_id_s == ID_W'(N_REQ-1)) ? '0 : grant_id_s + ID_W'(1);

`ifdef XMUL_ARB_LOCK_EN
  assign lock_s = bus.req_lock[grant_id_s];
`else
  assign lock_s = 1'b0;
`endif

  assign ptr_d = xfer_s ? (lock_s ? grant_id_s : ptr_inc_s) : ptr_q;

  assign a_ext_s = {{DATA_W{s1_a_q[DATA_W-1]}}, s1_a_q};
  assign b_ext_s = {{DATA_W{s1_b_q[DATA_W-1]}}, s1_b_q};
  assign prod_s  = a_ext_s * b_ext_s;

  // Both stages advance together; bubbles flow through when not stalled.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_fns_d   = s1_fns_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_prod_d  = s2_prod_q;
    s2_fns_d   = s2_fns_q;
    s2_id_d    = s2_id_q;
    if (!stall_s) begin
      s1_valid_d = xfer_s;
      s1_a_d     = xfer_s ? a_arr_s[grant_id_s]   : s1_a_q;
      s1_b_d     = xfer_s ? b_arr_s[grant_id_s]   : s1_b_q;
      s1_fns_d   = xfer_s ? fns_arr_s[grant_id_s] : s1_fns_q;
      s1_id_d    = xfer_s ? grant_id_s            : s1_id_q;
      s2_valid_d = s1_valid_q;
      s2_prod_d  = prod_s;
      s2_fns_d   = s1_fns_q;
      s2_id_d    = s1_id_q;
    end else begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_fns_q   <= 2'd0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_prod_q  <= '0;
      s2_fns_q   <= 2'd0;
      s2_id_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_fns_q   <= s1_fns_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_prod_q  <= s2_prod_d;
      s2_fns_q   <= s2_fns_d;
      s2_id_q    <= s2_id_d;
    end
  end

  // HI drops the redundant sign bit; DIV2_HI is the plain upper half.
  always_comb begin
    case (s2_fns_q)
      2'd1:    rsp_data_s = s2_prod_q[2*DATA_W-2 -: DATA_W];
      2'd2:    rsp_data_s = s2_prod_q[2*DATA_W-1 -: DATA_W];
      default: rsp_data_s = s2_prod_q[DATA_W-1:0];
    endcase
  end

  assign bus.req_ready = ready_s;
  assign bus.rsp_valid = s2_valid_q;
  assign bus.rsp_id    = s2_id_q;
  assign bus.rsp_data  = rsp_data_s;
endmodule

// File: doc/xmul_arb.md
XMUL_ARB -- requirements
Module: xmul_arb

Interface
REQ-001 Parameter DATA_W, default 32, shall set the operand and result width.
REQ-002 Parameter N_REQ, default 4, shall set the number of requesters (2..8); ID_W = clog2(N_REQ).
REQ-003 clk  input  1  shall be the single clock; all state changes on the rising edge.
REQ-004 rst  input  1  shall be the synchronous, active-high reset.
REQ-005 req_valid  input  N_REQ  shall flag, per requester, that an operation is offered.
REQ-006 req_ready  output  N_REQ  shall flag, per requester, acceptance this cycle (at most one bit set).
REQ-007 req_a  input  N_REQ*DATA_W  shall carry signed operand A of each requester; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 req_b  input  N_REQ*DATA_W  shall carry signed operand B, packed the same way.
REQ-009 req_fns  input  N_REQ*2  shall carry the result-select function per requester (0 LO, 1 HI, 2 DIV2_HI, 3 LO).
REQ-010 rsp_valid  output  1  shall flag a result on rsp_data.
REQ-011 rsp_id  output  ID_W  shall give the index of the requester that owns rsp_data.
REQ-012 rsp_data  output  DATA_W  shall carry the selected product slice.
REQ-013 rsp_ready  input  1  shall flag that the consumer takes the result this cycle.

Function
REQ-014 A transfer shall occur on requester i when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-015 req_ready shall be all-zero when the pipeline is stalled; otherwise it shall be one-hot for the granted valid requester, or all-zero if none is valid.
REQ-016 Arbitration shall be round-robin: search starts at pointer P and wraps N_REQ-1 -> 0; after a grant to i, P becomes (i+1) mod N_REQ; P holds when nothing is granted.
REQ-017 req_ready shall be combinational from req_valid, P and the stall condition; req_ready shall not depend on rsp_ready except through the stall condition.
REQ-018 Stage 1 shall register A, B, fns, id and a valid bit on transfer; stage 2 shall register the 2*DATA_W signed product of the stage-1 operands with fns, id and valid.
REQ-019 Stage 2 shall drive the outputs: a result is visible on rsp_* two cycles after its transfer edge when no stall occurs.
REQ-020 Slice selection: LO = product[DATA_W-1:0]; HI = product[2*DATA_W-2 -: DATA_W]; DIV2_HI = product[2*DATA_W-1 -: DATA_W].
REQ-021 Stall shall be asserted whenever rsp_valid=1 and rsp_ready=0; during a stall both stages shall hold, no grant shall be issued and P shall hold.
REQ-022 Bubbles (valid=0) shall advance freely; a full stage 1 behind an empty stage 2 shall not stall.
REQ-023 Throughput shall be one operation per cycle when rsp_ready stays high; no result shall be dropped or duplicated.
REQ-024 Results shall emerge in grant order; rsp_id, rsp_data and rsp_valid shall stay stable while stalled.
REQ-025 The most negative operand pair (-2^(DATA_W-1) x -2^(DATA_W-1)) shall yield product 2^(2*DATA_W-2) with no saturation.

Reset
REQ-026 While rst is high at an edge, both stage valid bits, rsp_valid, rsp_id, rsp_data and all stage data registers shall clear to 0, and P shall be 0.
REQ-027 Reset asserted mid-operation shall discard all in-flight results; no rsp_valid shall appear for them.
REQ-028 req_ready shall be all-zero while rst is high.

Configuration
REQ-029 Macro XMUL_ARB_LOCK_EN, when defined, shall add input req_lock (N_REQ bits); a transfer from i with req_lock[i]=1 shall leave P at i, so i keeps top priority while it keeps requesting.
REQ-030 Without XMUL_ARB_LOCK_EN, port req_lock shall not exist and arbitration shall be pure round-robin per REQ-016.

Verification
REQ-031 Single op: after reset, requester 2 offers A=3, B=-5, fns=0, rsp_ready=1 -> req_ready=4'b0100 at cycle 0; rsp_valid=1, rsp_id=2, rsp_data=-15 at cycle 2.
REQ-032 Fairness: all four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; rsp_id sequence matches, with 2-cycle lag.
REQ-033 Backpressure: stream of 3 ops, rsp_ready low for 4 cycles once the first result appears -> req_ready all-zero during the stall, rsp_* held stable, all 3 results delivered in order after release.
REQ-034 Functions, DATA_W=32: A=B=0x80000000 -> LO returns 0, HI returns 0x80000000, DIV2_HI returns 0x40000000.
REQ-035 Reset mid-flight: rst pulsed 1 cycle with 2 ops in the pipeline -> no rsp_valid afterwards, P=0, next grant goes to the lowest valid index.
REQ-036 With XMUL_ARB_LOCK_EN: requester 1 locked with continuous valid while 0 and 3 also request -> consecutive grants to 1 until req_lock[1] drops, then grant to 3.
